pipe_stage_skid: RTL and testbench

- Parametrised, handshaked pipeline-stage register. Next-generation replacement for the fixed-field, stall/flush-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic payload split into two fields:
  - a control field, zeroed on flush (bubble-safe);
  - a data field, which is not cleared on flush.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and back-pressure does not form a combinational path through the pipeline.

---
 rtl/pipe_stage_skid_pkg.sv | 9 +
 rtl/pipe_stage_skid_sat_counter.sv | 27 ++
 rtl/pipe_stage_skid.sv | 117 +++++++++++
 tb/tb_pipe_stage_skid.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the handshaked pipeline-stage register.
// State encoding and performance-counter width.
package pipe_stage_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} ps_state_t;

  localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with a per-cycle increment amount and synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W     = 32,
  parameter int INC_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);

  logic [W:0] sum;

  assign sum = {1'b0, cnt} + {{(W + 1 - INC_W){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (sum[W]) begin
      cnt <= '1;
    end else begin
      cnt <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer; in_ready is registered.
// Optional stall/flush counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
  import pipe_stage_pkg::*;
#(
  parameter int                 CTRL_W     = 16,
  parameter int                 DATA_W     = 128,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_fire, out_fire;
  ps_state_t         state;

  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign in_ready  = !skid_v;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state = PS_EMPTY;
    if (main_v) state = skid_v ? PS_FULL : PS_ONE;
  end

  // Storage update: reset beats flush; flush zeroes ctrl but leaves data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_data <= RESET_DATA;
      skid_data <= RESET_DATA;
    end else if (flush) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_fire) begin
            main_v    <= 1'b1;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_v    <= 1'b1;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_fire) begin
            main_v <= 1'b0;
          end
        end
        PS_FULL: begin
          if (out_fire) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_v    <= 1'b0;
          end
        end
        default: begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [1:0] stall_inc, flush_inc;

  assign stall_inc = {1'b0, out_valid & ~out_ready};
  assign flush_inc = flush ? ({1'b0, main_v} + {1'b0, skid_v}) : 2'd0;

  sat_counter #(.W(PERF_CNT_W), .INC_W(2)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc),
    .cnt (perf_stall_cnt)
  );

  sat_counter #(.W(PERF_CNT_W), .INC_W(2)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (flush_inc),
    .cnt (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue of held entries models the stage.
// Directed scenarios followed by randomized valid/ready/flush traffic.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] RST_D = 32'h8000_0000;
  localparam int PW = CTRL_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [31:0]       perf_stall_cnt, perf_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit en = 1'b0;
  logic [PW-1:0] q[$];

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RESET_DATA(RST_D)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ctrl        (in_ctrl),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ctrl       (out_ctrl),
    .out_data       (out_data),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: stage occupancy and head payload must match the model every cycle.
  always @(negedge clk) begin
    if (en) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("head", 64'({out_ctrl, out_data}), 64'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
      if (flush || reset) q.delete();
    end
  end

  // Stimulus side of the scoreboard: accepted payloads enter the model.
  always @(negedge clk) begin
    #1;
    if (en && in_valid && in_ready && !flush && !reset)
      q.push_back({in_ctrl, in_data});
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    cyc(2);
    reset = 1'b0;
    en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'(RST_D));
    cyc();

    // Back-to-back stream with downstream always ready.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, CTRL_W'(i + 1), DATA_W'(32'hA0 + i), 1'b1);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b1);
    cyc(3);

    // Fill to FULL with back-pressure, then drain.
    drive(1'b1, 8'd7, 32'h11, 1'b0);
    cyc();
    drive(1'b1, 8'd8, 32'h22, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    cyc(2);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_ctrl", 64'(out_ctrl), 64'd7);
    chk("full_head_data", 64'(out_data), 64'h11);
    cyc();
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    chk("drain_second_ctrl", 64'(out_ctrl), 64'd8);
    cyc(3);

    // Flush while FULL with a concurrent push that must be dropped.
    drive(1'b1, 8'd1, 32'h33, 1'b0);
    cyc();
    drive(1'b1, 8'd2, 32'h44, 1'b0);
    cyc();
    drive(1'b1, 8'd9, 32'h99, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    cyc(3);

    // Reset while FULL.
    drive(1'b1, 8'd3, 32'h55, 1'b0);
    cyc();
    drive(1'b1, 8'd4, 32'h66, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst2_out_data", 64'(out_data), 64'(RST_D));
    chk("rst2_in_ready", 64'(in_ready), 64'd1);
    chk("rst2_stall_cnt", 64'(perf_stall_cnt), 64'd0);
    cyc();

    // Counters: push two (one stall while the second enters), two more idle stalls,
    // then flush a FULL stage with out_ready high so the flush cycle is no stall.
    drive(1'b1, 8'h5a, 32'h77, 1'b0);
    cyc();
    drive(1'b1, 8'h5b, 32'h88, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    cyc(2);
    out_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
    chk("perf_flush", 64'(perf_flush_cnt), 64'd2);
`else
    chk("perf_stall", 64'(perf_stall_cnt), 64'd0);
    chk("perf_flush", 64'(perf_flush_cnt), 64'd0);
`endif
    cyc();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(1)), CTRL_W'($urandom), DATA_W'($urandom), 1'($urandom_range(1)));
      flush = ($urandom_range(63) == 0);
      cyc();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    cyc(4);
    @(negedge clk);
    chk("final_drained", 64'(q.size()), 64'd0);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
